// File: rtl/seg_scan_if.sv
// Bus bundle between a display-data source and the seg_scan_ctrl scanner.
// The source (master) drives enable/load/data; the scanner (slave) drives
// the shared-decoder feed and the anode enables.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    localparam int IW = $clog2(NDIG);

    logic               en;
    logic               load;
    logic [4*NDIG-1:0]  digits;
    logic [NDIG-1:0]    dps;
    logic               lzb;
    logic [3:0]         bcd;
    logic               dp;
    logic [NDIG-1:0]    an;
    logic [IW-1:0]      idx;
    logic               frame_done;

    modport master (
        output en, load, digits, dps, lzb,
        input  bcd, dp, an, idx, frame_done
    );

    modport slave (
        input  en, load, digits, dps, lzb,
        output bcd, dp, an, idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit is lit for DWELL cycles, followed by GUARD all-dark cycles.
// New display data waits in a staging buffer and is copied to the shadow
// buffer only at a frame wrap (or while idle), so a frame is never torn.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 5000,
    parameter int GUARD = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int IW      = $clog2(NDIG);
    localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] L_DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] L_GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0] L_IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [NDIG-1:0]    r_an, w_an_nxt;
    logic [3:0]         r_bcd, w_bcd_nxt;
    logic               r_dp, w_dp_nxt;
    logic               r_fd, w_fd_nxt;

    logic [4*NDIG-1:0]  r_stg, r_shadow, w_shadow_nxt;
    logic [NDIG-1:0]    r_stg_dp, r_shadow_dp, w_shadow_dp_nxt;
    logic               r_pending;

    logic               w_last_show, w_last_blank, w_slot_end;
    logic               w_wrap, w_reload, w_enter_show;
    logic               w_upper_nonzero, w_blank_digit;

    // Slot-end detection, frame wrap and the shadow value seen by the next slot.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_last_show     = (r_state == SHOW) && (r_cnt == L_DWELL_LAST);
        w_last_blank    = (GUARD > 0) && (r_state == BLANK) && (r_cnt == L_GUARD_LAST);
        w_slot_end      = (GUARD > 0) ? w_last_blank : w_last_show;
        w_wrap          = bus.en && w_slot_end && (r_idx == L_IDX_LAST);
        // A load seen during a wrap or while idle goes straight to shadow.
        w_reload        = w_wrap || ((r_state == IDLE) && (r_pending || bus.load));
        w_shadow_nxt    = r_shadow;
        w_shadow_dp_nxt = r_shadow_dp;
        if (w_reload) begin
            w_shadow_nxt    = bus.load ? bus.digits : r_stg;
            w_shadow_dp_nxt = bus.load ? bus.dps    : r_stg_dp;
        end
    end

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_idx_nxt       = r_idx;
        w_an_nxt        = r_an;
        w_bcd_nxt       = r_bcd;
        w_dp_nxt        = r_dp;
        w_fd_nxt        = 1'b0;
        w_enter_show    = 1'b0;
        w_upper_nonzero = 1'b0;
        w_blank_digit   = 1'b0;

        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_an_nxt    = '1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt  = SHOW;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    w_enter_show = 1'b1;
                end
                SHOW: begin
                    if (w_last_show) begin
                        w_cnt_nxt = '0;
                        if (GUARD > 0) begin
                            w_state_nxt = BLANK;
                            w_an_nxt    = '1;
                        end else begin
                            w_idx_nxt    = (r_idx == L_IDX_LAST) ? '0 : r_idx + 1'b1;
                            w_enter_show = 1'b1;
                            w_fd_nxt     = w_wrap;
                        end
                    end
                end
                BLANK: begin
                    if (w_last_blank) begin
                        w_state_nxt  = SHOW;
                        w_cnt_nxt    = '0;
                        w_idx_nxt    = (r_idx == L_IDX_LAST) ? '0 : r_idx + 1'b1;
                        w_enter_show = 1'b1;
                        w_fd_nxt     = w_wrap;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_an_nxt    = '1;
                end
            endcase
        end

        // Entering a SHOW slot: latch the digit and decide on leading-zero blanking.
        if (w_enter_show) begin
            for (int j = 0; j < NDIG; j++) begin
                if ((j >= int'(w_idx_nxt)) && (w_shadow_nxt[4*j +: 4] != 4'h0)) begin
                    w_upper_nonzero = 1'b1;
                end
            end
            w_blank_digit = bus.lzb && (w_idx_nxt != '0) && !w_upper_nonzero;
            w_bcd_nxt     = w_shadow_nxt[4*w_idx_nxt +: 4];
            w_dp_nxt      = w_shadow_dp_nxt[w_idx_nxt];
            w_an_nxt      = w_blank_digit ? '1 : ~(NDIG'(1) << w_idx_nxt);
        end
    end

    // Sequencer registers, registered outputs and the staging/shadow buffers.
    always_ff @(posedge clk) begin
        // NOTE: the data buffers are ordinary flops, not RAM, so they take a
        // defined reset value like every other register here.
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_an        <= '1;
            r_bcd       <= '0;
            r_dp        <= 1'b0;
            r_fd        <= 1'b0;
            r_stg       <= '0;
            r_stg_dp    <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pending   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational blocks.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_an        <= w_an_nxt;
            r_bcd       <= w_bcd_nxt;
            r_dp        <= w_dp_nxt;
            r_fd        <= w_fd_nxt;
            r_shadow    <= w_shadow_nxt;
            r_shadow_dp <= w_shadow_dp_nxt;
            if (bus.load) begin
                r_stg    <= bus.digits;
                r_stg_dp <= bus.dps;
            end
            if (w_reload) begin
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.bcd        = r_bcd;
    assign bus.dp         = r_dp;
    assign bus.idx        = r_idx;
    assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: NDIG=4, DWELL=4 with GUARD=1 and GUARD=0.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_seg_scan_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg_scan_if #(.NDIG(4)) bus1 ();
    seg_scan_if #(.NDIG(4)) bus2 ();

    seg_scan_ctrl #(.NDIG(4), .DWELL(4), .GUARD(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    seg_scan_ctrl #(.NDIG(4), .DWELL(4), .GUARD(0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Checks one GUARD=1 frame of DUT1 starting at its first SHOW sample;
    // optionally drives a load (with new lzb) at frame sample ld_at.
    task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] dpv,
                               input bit lz, input bit fd0, input int ld_at,
                               input logic [15:0] ld_val, input logic [3:0] ld_dp, input bit ld_lz);
        for (int k = 0; k < 20; k++) begin
            int  slot;
            int  ph;
            bit  blanked;
            logic [3:0] exp_an;
            tick();
            bus1.load = 1'b0;
            slot    = k / 5;
            ph      = k % 5;
            blanked = lz && (slot != 0) && ((val >> (4 * slot)) == 16'h0);
            exp_an  = (ph == 4 || blanked) ? 4'hF : (4'hF & ~(4'b0001 << slot));
            check($sformatf("%s.an[%0d]", tag, k), 32'(bus1.an), 32'(exp_an));
            check($sformatf("%s.idx[%0d]", tag, k), 32'(bus1.idx), 32'(slot));
            check($sformatf("%s.fd[%0d]", tag, k), 32'(bus1.frame_done), (k == 0) ? 32'(fd0) : 32'd0);
            if (!blanked) begin
                check($sformatf("%s.bcd[%0d]", tag, k), 32'(bus1.bcd), 32'((val >> (4 * slot)) & 16'hF));
                check($sformatf("%s.dp[%0d]", tag, k), 32'(bus1.dp), 32'(dpv[slot]));
            end
            if (k == ld_at) begin
                bus1.load   = 1'b1;
                bus1.digits = ld_val;
                bus1.dps    = ld_dp;
                bus1.lzb    = ld_lz;
            end
        end
    endtask

    initial begin
        // First frame of 0x1234 with GUARD=1, entered from IDLE (no wrap pulse).
        for (int i = 0; i < 4; i++) tbl[i]      = '{1'b1, 4'b1110, 4'h4, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 4'b1111, 4'h4, 2'd0, 1'b0};
        for (int i = 5; i < 9; i++) tbl[i]      = '{1'b1, 4'b1101, 4'h3, 2'd1, 1'b0};
        tbl[9] = '{1'b1, 4'b1111, 4'h3, 2'd1, 1'b0};
        for (int i = 10; i < 14; i++) tbl[i]    = '{1'b1, 4'b1011, 4'h2, 2'd2, 1'b0};
        tbl[14] = '{1'b1, 4'b1111, 4'h2, 2'd2, 1'b0};
        for (int i = 15; i < 19; i++) tbl[i]    = '{1'b1, 4'b0111, 4'h1, 2'd3, 1'b0};
        tbl[19] = '{1'b1, 4'b1111, 4'h1, 2'd3, 1'b0};

        rst_n = 1'b0;
        bus1.en = 1'b0; bus1.load = 1'b0; bus1.digits = '0; bus1.dps = '0; bus1.lzb = 1'b0;
        bus2.en = 1'b0; bus2.load = 1'b0; bus2.digits = '0; bus2.dps = '0; bus2.lzb = 1'b0;
        tick();
        tick();
        check("rst.an", 32'(bus1.an), 32'hF);
        check("rst.bcd", 32'(bus1.bcd), 32'h0);
        check("rst.dp", 32'(bus1.dp), 32'h0);
        check("rst.idx", 32'(bus1.idx), 32'h0);
        check("rst.fd", 32'(bus1.frame_done), 32'h0);

        // Load 0x1234 while idle, then enable.
        rst_n = 1'b1;
        bus1.load = 1'b1; bus1.digits = 16'h1234;
        tick();
        bus1.load = 1'b0;
        check("idle.an", 32'(bus1.an), 32'hF);
        bus1.en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            bus1.en = tbl[k].en;
            check($sformatf("T.an[%0d]", k), 32'(bus1.an), 32'(tbl[k].an));
            check($sformatf("T.bcd[%0d]", k), 32'(bus1.bcd), 32'(tbl[k].bcd));
            check($sformatf("T.idx[%0d]", k), 32'(bus1.idx), 32'(tbl[k].idx));
            check($sformatf("T.fd[%0d]", k), 32'(bus1.frame_done), 32'(tbl[k].fd));
        end

        // Mid-frame load, wrap-cycle load, leading-zero blanking.
        check_frame("A", 16'h1234, 4'b0000, 1'b0, 1'b1, 6,  16'h5678, 4'b0101, 1'b0);
        check_frame("B", 16'h5678, 4'b0101, 1'b0, 1'b1, 19, 16'h9ABC, 4'b0000, 1'b0);
        check_frame("C", 16'h9ABC, 4'b0000, 1'b0, 1'b1, 19, 16'h0050, 4'b0000, 1'b1);
        check_frame("D", 16'h0050, 4'b0000, 1'b1, 1'b1, 19, 16'h0000, 4'b0000, 1'b1);
        check_frame("E", 16'h0000, 4'b0000, 1'b1, 1'b1, 19, 16'h4321, 4'b0000, 1'b0);

        // Frame of 0x4321 interrupted by reset while a load is pending.
        for (int k = 0; k < 7; k++) begin
            tick();
            bus1.load = 1'b0;
            if (k == 0) check("F.fd", 32'(bus1.frame_done), 32'h1);
            if (k < 4) check($sformatf("F.bcd[%0d]", k), 32'(bus1.bcd), 32'h1);
            if (k >= 5) check($sformatf("F.an[%0d]", k), 32'(bus1.an), 32'b1101);
        end
        bus1.load = 1'b1; bus1.digits = 16'h7777;
        tick();
        bus1.load = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rst2.an", 32'(bus1.an), 32'hF);
        check("rst2.bcd", 32'(bus1.bcd), 32'h0);
        check("rst2.dp", 32'(bus1.dp), 32'h0);
        check("rst2.idx", 32'(bus1.idx), 32'h0);
        check("rst2.fd", 32'(bus1.frame_done), 32'h0);
        rst_n = 1'b1;
        check_frame("R", 16'h0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0000, 4'b0000, 1'b0);

        // GUARD=0 instance: back-to-back slots, 16-cycle frame, en drop mid-slot.
        bus2.load = 1'b1; bus2.digits = 16'h1234;
        tick();
        bus2.load = 1'b0;
        bus2.en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("G.an[%0d]", k), 32'(bus2.an), 32'(4'hF & ~(4'b0001 << (k / 4))));
            check($sformatf("G.bcd[%0d]", k), 32'(bus2.bcd), 32'(4 - k / 4));
            check($sformatf("G.idx[%0d]", k), 32'(bus2.idx), 32'(k / 4));
            check($sformatf("G.fd[%0d]", k), 32'(bus2.frame_done), 32'h0);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                check("G.wrap.fd", 32'(bus2.frame_done), 32'h1);
                check("G.wrap.an", 32'(bus2.an), 32'b1110);
            end
            if (k == 9) begin
                check("G.d2.an", 32'(bus2.an), 32'b1011);
                bus2.en = 1'b0;
            end
        end
        tick();
        check("G.off.an", 32'(bus2.an), 32'hF);
        check("G.off.idx", 32'(bus2.idx), 32'h0);
        check("G.off.fd", 32'(bus2.frame_done), 32'h0);
        bus2.en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("G.re.an[%0d]", k), 32'(bus2.an), (k < 4) ? 32'b1110 : 32'b1101);
            check($sformatf("G.re.idx[%0d]", k), 32'(bus2.idx), (k < 4) ? 32'd0 : 32'd1);
            check($sformatf("G.re.fd[%0d]", k), 32'(bus2.frame_done), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
